// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared default geometry for the register file. Other blocks import this
//   package so that the register file size has one definition.
package reg_file_pkg;

    localparam int unsigned REG_FILE_WIDTH = 16;
    localparam int unsigned REG_FILE_ADDR  = 3;
    localparam int unsigned REG_FILE_DEPTH = 2 ** REG_FILE_ADDR;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// reg_file
//   DEPTH x WIDTH register file with a single shared address, a synchronous
//   write port and a registered read port (one-cycle read latency).
//
// Ports
//   CLK      in   1      clock, all state changes on the rising edge
//   RST      in   1      synchronous active-high reset, clears storage and RdData
//   WrEn     in   1      write enable; wins over RdEn when both are high
//   RdEn     in   1      read enable; RdData holds its value when low
//   Address  in   ADDR   register select for the read or write
//   WrData   in   WIDTH  write data, stored as-is
//   RdData   out  WIDTH  registered read data
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = REG_FILE_WIDTH,
    parameter int unsigned DEPTH = REG_FILE_DEPTH,
    parameter int unsigned ADDR  = REG_FILE_ADDR
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WrEn,
    input  logic             RdEn,
    input  logic [ADDR-1:0]  Address,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] RdData
);

    logic [WIDTH-1:0] regs [DEPTH];

    // A simultaneous write and read performs only the write; RdData keeps
    // its previous value rather than returning old or new data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            regs   <= '{default: '0};
            RdData <= '0;
        end else if (WrEn) begin
            regs[Address] <= WrData;
        end else if (RdEn) begin
            RdData <= regs[Address];
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Self-checking bench for reg_file: directed scenarios followed by random
//   traffic, compared against an array-based reference model.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned A = 3;
    localparam int unsigned D = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         WrEn;
    logic         RdEn;
    logic [A-1:0] Address;
    logic [W-1:0] WrData;
    logic [W-1:0] RdData;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the register contents and the expected read output.
    logic [W-1:0] mem [D];
    logic [W-1:0] rd_exp;

    reg_file #(.WIDTH(W), .DEPTH(D), .ADDR(A)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .Address (Address),
        .WrData  (WrData),
        .RdData  (RdData)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, and
    // compare RdData with the model just after the edge.
    task automatic step(input string tag, input logic rst, input logic we, input logic re,
                        input logic [A-1:0] a, input logic [W-1:0] d);
        RST = rst; WrEn = we; RdEn = re; Address = a; WrData = d;
        @(posedge CLK);
        #1;
        if (rst) begin
            foreach (mem[i]) mem[i] = '0;
            rd_exp = '0;
        end else if (we) begin
            mem[a] = d;
        end else if (re) begin
            rd_exp = mem[a];
        end
        check(tag, RdData, rd_exp);
    endtask

    initial begin
        logic [W-1:0] xval;
        logic [W-1:0] rnd_d;
        logic [A-1:0] rnd_a;
        logic         rnd_rst, rnd_we, rnd_re;

        foreach (mem[i]) mem[i] = '0;
        rd_exp = '0;

        // Reset, then read address 1
        step("reset", 1, 0, 0, 0, 16'h0);
        check("reset_rddata", RdData, 16'h0000);
        step("read1_after_reset", 0, 0, 1, 1, 16'h0);
        check("read1_zero", RdData, 16'h0000);

        // Writes then reads, with a hold cycle in between
        step("wr3", 0, 1, 0, 3, 16'h000B);
        step("wr7", 0, 1, 0, 7, 16'h0001);
        step("wr1", 0, 1, 0, 1, 16'h001C);
        step("rd3", 0, 0, 1, 3, 16'h0);
        check("rd3_val", RdData, 16'h000B);
        step("hold", 0, 0, 0, 7, 16'h0);
        check("hold_val", RdData, 16'h000B);
        step("rd1", 0, 0, 1, 1, 16'h0);
        check("rd1_val", RdData, 16'h001C);
        step("rd7", 0, 0, 1, 7, 16'h0);
        check("rd7_val", RdData, 16'h0001);

        // Simultaneous write and read: write only, output holds
        step("wr_rd_same", 0, 1, 1, 2, 16'h1234);
        check("simul_hold", RdData, 16'h0001);
        step("rd2", 0, 0, 1, 2, 16'h0);
        check("rd2_val", RdData, 16'h1234);

        // Reset beats a concurrent write
        step("wr5", 0, 1, 0, 5, 16'h5555);
        step("rst_with_wr", 1, 1, 0, 5, 16'hFFFF);
        check("rst_rddata_zero", RdData, 16'h0000);
        step("rd5_after_rst", 0, 0, 1, 5, 16'h0);
        check("rd5_zero", RdData, 16'h0000);
        step("rd3_after_rst", 0, 0, 1, 3, 16'h0);
        check("rd3_zero", RdData, 16'h0000);

        // Full sweep
        for (int i = 0; i < int'(D); i++)
            step("sweep_wr", 0, 1, 0, A'(i), 16'hA000 + W'(i));
        for (int i = 0; i < int'(D); i++) begin
            step("sweep_rd", 0, 0, 1, A'(i), 16'h0);
            check("sweep_val", RdData, 16'hA000 + W'(i));
        end

        // Unknown data is stored verbatim
        xval = 'x;
        step("wr6_x", 0, 1, 0, 6, xval);
        step("rd6_x", 0, 0, 1, 6, 16'h0);
        check("x_stored", RdData, xval);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rnd_rst = ($urandom_range(0, 39) == 0);
            rnd_we  = 1'($urandom);
            rnd_re  = 1'($urandom);
            rnd_a   = A'($urandom);
            rnd_d   = W'($urandom);
            step("random", rnd_rst, rnd_we, rnd_re, rnd_a, rnd_d);
        end

        // Final readback of every register
        for (int i = 0; i < int'(D); i++)
            step("final_rd", 0, 0, 1, A'(i), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of registers.
REQ-003 Parameter ADDR, default 3, SHALL set the address width, with DEPTH = 2**ADDR.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 WrEn  input  1  SHALL be the write enable.
REQ-007 RdEn  input  1  SHALL be the read enable.
REQ-008 Address  input  ADDR  SHALL select the register for a read or write.
REQ-009 WrData  input  WIDTH  SHALL carry the write data.
REQ-010 RdData  output  WIDTH  SHALL carry the registered read data.

Function
REQ-011 Storage SHALL be DEPTH registers of WIDTH bits, indexed 0..DEPTH-1 by Address.
REQ-012 Write: at a rising edge with RST=0, WrEn=1 and RdEn=0, the block SHALL load reg[Address] with WrData; the new value is visible to a read issued at the next edge.
REQ-013 Read: at a rising edge with RST=0, RdEn=1 and WrEn=0, the block SHALL load RdData with reg[Address], giving one-cycle latency.
REQ-014 When RdEn=0, RdData SHALL hold its last value.
REQ-015 When WrEn=1 and RdEn=1 at the same edge, the block SHALL perform the write only, and RdData SHALL hold its value.
REQ-016 When WrEn=0 and RdEn=0, no register and no output SHALL change.
REQ-017 Every Address value 0..DEPTH-1 SHALL be valid; no wrap-around or out-of-range case exists for DEPTH = 2**ADDR.
REQ-018 Unselected registers SHALL never change on a write.
REQ-019 X or unknown WrData written while WrEn=1 SHALL be stored as-is; no data checking is performed.

Reset
REQ-020 At a rising edge with RST=1, all DEPTH registers and RdData SHALL be cleared to 0.
REQ-021 Reset SHALL take priority over WrEn and RdEn at the same edge.
REQ-022 Reset asserted mid-operation SHALL discard any pending write or read at that edge.
REQ-023 After reset deassertion, the first read of any address SHALL return 0 until that address is written.

Structure
REQ-024 The WIDTH/DEPTH/ADDR defaults SHALL live in a shared package, reg_file_pkg, as constants.
REQ-025 The block SHALL be a single module with no sub-modules: a register array plus a registered output, written as one clocked process.
REQ-026 The design SHALL be fully synchronous, with no latches and no combinational path from inputs to RdData.

Verification
REQ-027 Reset: hold RST=1 for one edge, then RdEn=1, Address=1 -> RdData=0x0000 one cycle later.
REQ-028 Writes then reads: write reg[3]=0x000B, reg[7]=0x0001, reg[1]=0x001C on successive edges; then read 3, 7, 1 -> RdData=0x000B, 0x0001, 0x001C, each one cycle after its request.
REQ-029 Hold: after reading reg[3]=0x000B, drive RdEn=0, change Address to 7 -> RdData stays 0x000B.
REQ-030 Simultaneous: with RdData=0x0001, drive WrEn=1, RdEn=1, Address=2, WrData=0x1234 -> RdData stays 0x0001; a later read of 2 returns 0x1234.
REQ-031 Reset priority: drive RST=1 with WrEn=1, Address=5, WrData=0xFFFF -> a read of 5 after reset returns 0x0000, and RdData=0 during reset.
REQ-032 Full sweep: write 0xA000+i to every address i=0..7, then read all -> each returns 0xA000+i, and no other register is corrupted.
